// File: rtl/edge_ts_pkg.sv
// Shared types and constants for the edge timestamp capture block.
// evt_t is the event record at the default timestamp width.
package edge_ts_pkg;

  localparam int TS_W_DEF = 16;
  localparam int DROP_MAX = 255;

  typedef struct packed {
    logic                level;
    logic [TS_W_DEF-1:0] tstamp;
    logic [TS_W_DEF-1:0] delta;
  } evt_t;

endpackage

// File: rtl/edge_ts_if.sv
// Event stream from the capture block to a checker or log sink.
// The master drives the FIFO head and status; the slave returns ready.
interface edge_ts_if #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_level;
  logic [TS_W-1:0]  evt_time;
  logic [TS_W-1:0]  evt_delta;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic [7:0]       drop_cnt;

  modport master (
    output evt_valid, evt_level, evt_time, evt_delta, evt_count, overflow, drop_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_level, evt_time, evt_delta, evt_count, overflow, drop_cnt,
    output evt_ready
  );
endinterface

// File: rtl/edge_ts_fifo.sv
// Synchronous show-ahead FIFO: dout always shows the oldest entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module edge_ts_fifo
  import edge_ts_pkg::*;
#(
  parameter type T     = evt_t,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  T            din,
  input  logic        pop,
  output T            dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout     = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/edge_timestamp_capture.sv
// Samples sig_in and queues every level transition as {level, timestamp, delta}.
// Outputs read as zero whenever the FIFO is empty.
module edge_timestamp_capture
  import edge_ts_pkg::*;
#(
  parameter int TS_W    = TS_W_DEF,
  parameter int DEPTH   = 8,
  parameter int SYNC_EN = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      sig_in,
  edge_ts_if.master evt
);

  // Two synchroniser flops ahead of the sample flop when sig_in is asynchronous.
  localparam int         NSTAGE = (SYNC_EN != 0) ? 3 : 1;
  localparam int         AW     = $clog2(DEPTH);
  localparam logic [2:0] ARM_AT = 3'(NSTAGE + 1);

  typedef struct packed {
    logic            level;
    logic [TS_W-1:0] tstamp;
    logic [TS_W-1:0] delta;
  } ev_t;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
    return (&v) ? v : v + TS_W'(1);
  endfunction

  logic [NSTAGE-1:0] smp_q, smp_d;
  logic              s_prev_q, s_prev_d;
  logic              s_cur;
  logic [2:0]        vcnt_q, vcnt_d;
  logic              armed, evt_hit, drop;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   el_q, el_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;
  ev_t               push_data, head;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;

  always_comb begin
    smp_d      = NSTAGE'({smp_q, sig_in});
    s_cur      = smp_q[NSTAGE-1];
    s_prev_d   = s_cur;
    // Armed once s_prev holds a sample taken after release; that first level is baseline only.
    armed      = (vcnt_q == ARM_AT);
    vcnt_d     = armed ? vcnt_q : vcnt_q + 3'd1;
    evt_hit    = armed && (s_cur != s_prev_q);
    ts_d       = ts_q + TS_W'(1);
    // el tracks ts - ts_last but sticks at all-ones instead of wrapping.
    el_d       = evt_hit ? TS_W'(1) : sat_inc(el_q);
    push_data  = '{level: s_cur, tstamp: ts_q, delta: el_q};
    drop       = evt_hit && fifo_full && !evt.evt_ready;
    overflow_d = overflow_q || drop;
    drop_d     = (drop && drop_q != 8'(DROP_MAX)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    smp_q    <= smp_d;
    s_prev_q <= s_prev_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      vcnt_q     <= '0;
      ts_q       <= '0;
      el_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      vcnt_q     <= vcnt_d;
      ts_q       <= ts_d;
      el_q       <= el_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  edge_ts_fifo #(
    .T     (ev_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (evt_hit),
    .din   (push_data),
    .pop   (evt.evt_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_level = !fifo_empty && head.level;
  assign evt.evt_time  = fifo_empty ? '0 : head.tstamp;
  assign evt.evt_delta = fifo_empty ? '0 : head.delta;
  assign evt.evt_count = fifo_count;
  assign evt.overflow  = overflow_q;
  assign evt.drop_cnt  = drop_q;

endmodule

// File: tb/tb_edge_timestamp_capture.sv
// Directed bench: a 16-bit/depth-8 instance for the main scenarios and a
// 4-bit/depth-4 instance for timestamp wrap and delta saturation.
module tb_edge_timestamp_capture;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b, clear_a, clear_b, sig_a, sig_b;
  int   total = 0;
  int   bad   = 0;

  edge_ts_if #(.TS_W(16), .CNT_W(4)) ifa ();
  edge_ts_if #(.TS_W(4),  .CNT_W(3)) ifb ();

  edge_timestamp_capture #(.TS_W(16), .DEPTH(8), .SYNC_EN(0)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n_a),
    .clear  (clear_a),
    .sig_in (sig_a),
    .evt    (ifa)
  );

  edge_timestamp_capture #(.TS_W(4), .DEPTH(4), .SYNC_EN(0)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n_b),
    .clear  (clear_b),
    .sig_in (sig_b),
    .evt    (ifb)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0;
    tick(2);
    rst_n_a = 1'b1;
  endtask

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    sig_a = 1'b0; sig_b = 1'b0;
    ifa.evt_ready = 1'b1; ifb.evt_ready = 1'b1;

    // Reset state
    tick(2);
    chk("rst_valid", ifa.evt_valid, 0);
    chk("rst_count", ifa.evt_count, 0);
    chk("rst_overflow", ifa.overflow, 0);
    chk("rst_drop", ifa.drop_cnt, 0);
    rst_n_a = 1'b1;

    // 1: rise before edge 5, fall before edge 9
    tick(2);
    chk("t1_no_initial", ifa.evt_valid, 0);
    tick(1); sig_a = 1'b1;
    tick(1);
    chk("t1_no_bypass", ifa.evt_valid, 0);
    tick(1);
    chk("t1_rise_valid", ifa.evt_valid, 1);
    chk("t1_rise_level", ifa.evt_level, 1);
    chk("t1_rise_time", ifa.evt_time, 4);
    chk("t1_rise_delta", ifa.evt_delta, 4);
    chk("t1_rise_count", ifa.evt_count, 1);
    tick(1);
    chk("t1_popped", ifa.evt_valid, 0);
    tick(1); sig_a = 1'b0;
    tick(2);
    chk("t1_fall_valid", ifa.evt_valid, 1);
    chk("t1_fall_level", ifa.evt_level, 0);
    chk("t1_fall_time", ifa.evt_time, 8);
    chk("t1_fall_delta", ifa.evt_delta, 4);

    // 2: high through release, then a fall
    sig_a = 1'b1;
    reset_a();
    ifa.evt_ready = 1'b0;
    tick(5);
    chk("t2_no_initial", ifa.evt_valid, 0);
    chk("t2_count0", ifa.evt_count, 0);
    sig_a = 1'b0;
    tick(2);
    chk("t2_valid", ifa.evt_valid, 1);
    chk("t2_level", ifa.evt_level, 0);
    chk("t2_time", ifa.evt_time, 6);
    chk("t2_delta", ifa.evt_delta, 6);
    chk("t2_count1", ifa.evt_count, 1);

    // 3: ten toggles into a depth-8 FIFO with no consumer
    reset_a();
    tick(3);
    for (int i = 0; i < 10; i++) begin
      sig_a = ~sig_a;
      tick(2);
    end
    chk("t3_count", ifa.evt_count, 8);
    chk("t3_drop", ifa.drop_cnt, 2);
    chk("t3_overflow", ifa.overflow, 1);
    ifa.evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_valid", ifa.evt_valid, 1);
      chk("t3_drain_level", ifa.evt_level, (i % 2 == 0) ? 1 : 0);
      chk("t3_drain_time", ifa.evt_time, 4 + 2 * i);
      chk("t3_drain_delta", ifa.evt_delta, (i == 0) ? 4 : 2);
      tick(1);
    end
    chk("t3_empty", ifa.evt_valid, 0);
    chk("t3_count0", ifa.evt_count, 0);

    // 4: refill to full, then pop in the same cycle as a new event
    ifa.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sig_a = ~sig_a;
      tick(2);
    end
    chk("t4_full", ifa.evt_count, 8);
    sig_a = ~sig_a;
    tick(1);
    ifa.evt_ready = 1'b1;
    tick(1);
    ifa.evt_ready = 1'b0;
    chk("t4_count", ifa.evt_count, 8);
    chk("t4_no_drop", ifa.drop_cnt, 2);
    chk("t4_head_time", ifa.evt_time, 34);
    chk("t4_head_level", ifa.evt_level, 0);

    // 6: clear with events queued and overflow set
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
    chk("t6_valid", ifa.evt_valid, 0);
    chk("t6_overflow", ifa.overflow, 0);
    chk("t6_drop", ifa.drop_cnt, 0);
    chk("t6_count", ifa.evt_count, 0);
    ifa.evt_ready = 1'b1;
    tick(4); sig_a = 1'b0;
    tick(2);
    chk("t6_evt_valid", ifa.evt_valid, 1);
    chk("t6_evt_level", ifa.evt_level, 0);
    chk("t6_evt_time", ifa.evt_time, 5);
    chk("t6_evt_delta", ifa.evt_delta, 5);

    // 5: 4-bit timestamps, event at 14 then 20 cycles later
    rst_n_b = 1'b1;
    tick(13); sig_b = 1'b1;
    tick(2);
    chk("t5_first_valid", ifb.evt_valid, 1);
    chk("t5_first_time", ifb.evt_time, 14);
    chk("t5_first_delta", ifb.evt_delta, 14);
    tick(18); sig_b = 1'b0;
    tick(2);
    chk("t5_wrap_valid", ifb.evt_valid, 1);
    chk("t5_wrap_level", ifb.evt_level, 0);
    chk("t5_wrap_time", ifb.evt_time, 2);
    chk("t5_sat_delta", ifb.evt_delta, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
